// File: rtl/alarm_trigger.sv
// Alarm trigger: compares BCD alarm setting against time of day, rings with a gated tone,
// supports snooze/dismiss/timeout. Define ALARM_SNOOZE_LIMIT_EN to cap snoozes at MAX_SNOOZE.
module alarm_trigger #(
  parameter int unsigned SNOOZE_SEC       = 300,
  parameter int unsigned RING_TIMEOUT_SEC = 60,
  parameter int unsigned BUZZ_HALF        = 25000,
  parameter int unsigned MAX_SNOOZE       = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic [3:0] alm_hourMSB,
  input  logic [3:0] alm_hourLSB,
  input  logic [3:0] alm_minMSB,
  input  logic [3:0] alm_minLSB,
  input  logic [3:0] alm_secMSB,
  input  logic [3:0] alm_secLSB,
  input  logic [3:0] tod_hourMSB,
  input  logic [3:0] tod_hourLSB,
  input  logic [3:0] tod_minMSB,
  input  logic [3:0] tod_minLSB,
  input  logic [3:0] tod_secMSB,
  input  logic [3:0] tod_secLSB,
  input  logic       alarm_en,
  input  logic       snooze,
  input  logic       dismiss,
  output logic       armed,
  output logic       ringing,
  output logic       snoozing,
  output logic       buzzer
);

  localparam int unsigned RingW = (RING_TIMEOUT_SEC > 1) ? $clog2(RING_TIMEOUT_SEC) : 1;
  localparam int unsigned SnzW  = (SNOOZE_SEC > 1) ? $clog2(SNOOZE_SEC) : 1;
  localparam int unsigned ToneW = (BUZZ_HALF > 1) ? $clog2(BUZZ_HALF) : 1;

  typedef enum logic [1:0] {StIdle, StArmed, StRinging, StSnooze} state_e;

  state_e           state_q, state_d;
  logic             eq, eq_q, match, snooze_ok;
  logic [RingW-1:0] ring_cnt_q, ring_cnt_d;
  logic [SnzW-1:0]  snz_cnt_q, snz_cnt_d;
  logic [ToneW-1:0] tone_cnt_q, tone_cnt_d;
  logic             tone_q, tone_d;

`ifdef ALARM_SNOOZE_LIMIT_EN
  localparam int unsigned NumW = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;
  logic [NumW-1:0] snz_num_q, snz_num_d;
  assign snooze_ok = (snz_num_q != NumW'(MAX_SNOOZE));
`else
  assign snooze_ok = 1'b1;
`endif

  assign eq = ({alm_hourMSB, alm_hourLSB, alm_minMSB, alm_minLSB, alm_secMSB, alm_secLSB} ==
               {tod_hourMSB, tod_hourLSB, tod_minMSB, tod_minLSB, tod_secMSB, tod_secLSB});
  // Rising edge of equality: one trigger per episode, including edits of the alarm setting.
  assign match = eq & ~eq_q;

  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
`ifdef ALARM_SNOOZE_LIMIT_EN
    snz_num_d  = snz_num_q;
`endif
    if (!alarm_en) begin
      state_d    = StIdle;
      ring_cnt_d = '0;
      snz_cnt_d  = '0;
`ifdef ALARM_SNOOZE_LIMIT_EN
      snz_num_d  = '0;
`endif
    end else begin
      case (state_q)
        StIdle: state_d = StArmed;
        StArmed: begin
          if (match) begin
            state_d    = StRinging;
            ring_cnt_d = '0;
          end
        end
        StRinging: begin
          if (dismiss) begin
            state_d = StArmed;
`ifdef ALARM_SNOOZE_LIMIT_EN
            snz_num_d = '0;
`endif
          end else if (snooze && snooze_ok) begin
            state_d   = StSnooze;
            snz_cnt_d = '0;
`ifdef ALARM_SNOOZE_LIMIT_EN
            snz_num_d = snz_num_q + NumW'(1);
`endif
          end else if (tick_1hz) begin
            if (ring_cnt_q == RingW'(RING_TIMEOUT_SEC - 1)) begin
              state_d = StArmed;
`ifdef ALARM_SNOOZE_LIMIT_EN
              snz_num_d = '0;
`endif
            end else begin
              ring_cnt_d = ring_cnt_q + RingW'(1);
            end
          end
        end
        StSnooze: begin
          if (dismiss) begin
            state_d = StArmed;
`ifdef ALARM_SNOOZE_LIMIT_EN
            snz_num_d = '0;
`endif
          end else if (tick_1hz) begin
            if (snz_cnt_q == SnzW'(SNOOZE_SEC - 1)) begin
              state_d    = StRinging;
              ring_cnt_d = '0;
            end else begin
              snz_cnt_d = snz_cnt_q + SnzW'(1);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // Tone runs only while staying in RINGING; every entry restarts it high.
    if (state_d == StRinging && state_q == StRinging) begin
      if (tone_cnt_q == ToneW'(BUZZ_HALF - 1)) begin
        tone_cnt_d = '0;
        tone_d     = ~tone_q;
      end else begin
        tone_cnt_d = tone_cnt_q + ToneW'(1);
        tone_d     = tone_q;
      end
    end else begin
      tone_cnt_d = '0;
      tone_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      eq_q       <= 1'b0;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
      tone_cnt_q <= '0;
      tone_q     <= 1'b1;
      buzzer     <= 1'b0;
`ifdef ALARM_SNOOZE_LIMIT_EN
      snz_num_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      eq_q       <= eq;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      tone_cnt_q <= tone_cnt_d;
      tone_q     <= tone_d;
      buzzer     <= (state_d == StRinging) & tone_d;
`ifdef ALARM_SNOOZE_LIMIT_EN
      snz_num_q  <= snz_num_d;
`endif
    end
  end

  assign armed    = (state_q == StArmed);
  assign ringing  = (state_q == StRinging);
  assign snoozing = (state_q == StSnooze);

endmodule

// File: tb/tb_alarm_trigger.sv
// Directed plus randomized bench for alarm_trigger against a tick-counting behavioural model.
module tb_alarm_trigger;

  localparam int SNZ = 3;
  localparam int RT  = 5;
  localparam int BH  = 2;
  localparam int MAXS = 3;

  localparam int MIdle = 0, MArmed = 1, MRing = 2, MSnz = 3;

  logic        clk = 1'b0;
  logic        reset, tick_1hz, alarm_en, snooze, dismiss;
  logic [23:0] alm, tod;
  logic        armed, ringing, snoozing, buzzer;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: mode, seconds left in the current timed mode, cycles since ring entry, snoozes used.
  int m_mode, m_left, m_age, m_used;
  bit m_eq_prev;

  alarm_trigger #(
    .SNOOZE_SEC(SNZ), .RING_TIMEOUT_SEC(RT), .BUZZ_HALF(BH), .MAX_SNOOZE(MAXS)
  ) dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
    .alm_hourMSB(alm[23:20]), .alm_hourLSB(alm[19:16]), .alm_minMSB(alm[15:12]),
    .alm_minLSB(alm[11:8]), .alm_secMSB(alm[7:4]), .alm_secLSB(alm[3:0]),
    .tod_hourMSB(tod[23:20]), .tod_hourLSB(tod[19:16]), .tod_minMSB(tod[15:12]),
    .tod_minLSB(tod[11:8]), .tod_secMSB(tod[7:4]), .tod_secLSB(tod[3:0]),
    .alarm_en(alarm_en), .snooze(snooze), .dismiss(dismiss),
    .armed(armed), .ringing(ringing), .snoozing(snoozing), .buzzer(buzzer)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = MIdle; m_left = 0; m_age = 0; m_used = 0; m_eq_prev = 1'b0;
  endtask

  task automatic enter_ring();
    m_mode = MRing; m_left = RT; m_age = 0;
  endtask

  // Advance the model by one clock using the inputs the DUT is about to sample.
  task automatic model_step();
    bit eq_now, rise, allow;
    eq_now = (alm == tod);
    rise = eq_now && !m_eq_prev;
    m_eq_prev = eq_now;
`ifdef ALARM_SNOOZE_LIMIT_EN
    allow = (m_used < MAXS);
`else
    allow = 1'b1;
`endif
    if (!alarm_en) begin
      m_mode = MIdle; m_used = 0;
    end else begin
      case (m_mode)
        MIdle: m_mode = MArmed;
        MArmed: if (rise) enter_ring();
        MRing: begin
          m_age++;
          if (dismiss) begin
            m_mode = MArmed; m_used = 0;
          end else if (snooze && allow) begin
            m_mode = MSnz; m_left = SNZ; m_used++;
          end else if (tick_1hz) begin
            m_left--;
            if (m_left == 0) begin m_mode = MArmed; m_used = 0; end
          end
        end
        default: begin
          if (dismiss) begin
            m_mode = MArmed; m_used = 0;
          end else if (tick_1hz) begin
            m_left--;
            if (m_left == 0) enter_ring();
          end
        end
      endcase
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "/armed"}, armed, m_mode == MArmed);
    check({tag, "/ringing"}, ringing, m_mode == MRing);
    check({tag, "/snoozing"}, snoozing, m_mode == MSnz);
    check({tag, "/buzzer"}, buzzer, (m_mode == MRing) && ((m_age / BH) % 2 == 0));
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic pulse_tick();
    tick_1hz = 1'b1; cycle("tick"); tick_1hz = 1'b0; cycle("post_tick");
  endtask

  task automatic retrigger();
    tod = 24'h072959; cycle("pre_match");
    tod = 24'h073000; cycle("match");
    check("retrigger_ringing", ringing, 1'b1);
  endtask

  initial begin
    logic exp_buz [5];
    exp_buz = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    reset = 1'b1; tick_1hz = 1'b0; alarm_en = 1'b1; snooze = 1'b0; dismiss = 1'b0;
    alm = 24'h073000; tod = 24'h072959;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    reset = 1'b0;
    cycle("release");
    check("armed_after_reset", armed, 1'b1);

    // First match: tone starts high and toggles every BH cycles.
    tod = 24'h073000;
    cycle("first_match");
    check("first_ring", ringing, 1'b1);
    check("first_buzz", buzzer, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle("tone");
      check("tone_pattern", buzzer, exp_buz[i]);
    end

    // Unattended timeout, then no retrigger while time stays equal.
    for (int i = 0; i < RT; i++) pulse_tick();
    check("timeout_ringing", ringing, 1'b0);
    check("timeout_armed", armed, 1'b1);
    repeat (4) cycle("no_retrigger");
    check("no_retrigger_ring", ringing, 1'b0);

    // Snooze, resume, dismiss.
    retrigger();
    snooze = 1'b1; cycle("snooze"); snooze = 1'b0;
    check("snoozing", snoozing, 1'b1);
    check("snooze_buzz_off", buzzer, 1'b0);
    for (int i = 0; i < SNZ; i++) pulse_tick();
    check("resume_ring", ringing, 1'b1);
    dismiss = 1'b1; cycle("dismiss"); dismiss = 1'b0;
    check("dismiss_armed", armed, 1'b1);

    // Dismiss beats snooze.
    retrigger();
    dismiss = 1'b1; snooze = 1'b1; cycle("both"); dismiss = 1'b0; snooze = 1'b0;
    check("both_armed", armed, 1'b1);
    check("both_not_snoozing", snoozing, 1'b0);

    // Snooze coincident with a timeout tick goes to snooze.
    retrigger();
    for (int i = 0; i < RT - 1; i++) pulse_tick();
    snooze = 1'b1; tick_1hz = 1'b1; cycle("snooze_timeout");
    snooze = 1'b0; tick_1hz = 1'b0;
    check("snooze_timeout_snoozing", snoozing, 1'b1);

    // alarm_en drop during snooze, then re-arm without a fresh match.
    alarm_en = 1'b0; cycle("en_low");
    check("en_low_armed", armed, 1'b0);
    check("en_low_snoozing", snoozing, 1'b0);
    alarm_en = 1'b1; cycle("en_high");
    check("en_high_armed", armed, 1'b1);
    repeat (4) pulse_tick();
    check("en_high_no_ring", ringing, 1'b0);

`ifdef ALARM_SNOOZE_LIMIT_EN
    retrigger();
    for (int k = 0; k < MAXS; k++) begin
      snooze = 1'b1; cycle("limit_snooze"); snooze = 1'b0;
      for (int i = 0; i < SNZ; i++) pulse_tick();
    end
    snooze = 1'b1; cycle("limit_ignored"); snooze = 1'b0;
    check("limit_still_ringing", ringing, 1'b1);
    for (int i = 0; i < RT; i++) pulse_tick();
    check("limit_timeout_armed", armed, 1'b1);
`endif

    // Asynchronous reset while ringing.
    retrigger();
    #3 reset = 1'b1;
    #1;
    model_reset();
    check("async_reset_ringing", ringing, 1'b0);
    check("async_reset_buzzer", buzzer, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    cycle("post_reset");

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      tick_1hz = ($urandom_range(3) == 0);
      snooze   = ($urandom_range(11) == 0);
      dismiss  = ($urandom_range(29) == 0);
      if ($urandom_range(149) == 0) alarm_en = ~alarm_en;
      if ($urandom_range(24) == 0) tod = ($urandom_range(1) == 0) ? alm : 24'($urandom);
      if ($urandom_range(299) == 0) alm = 24'($urandom);
      cycle("random");
    end
    tick_1hz = 1'b0; snooze = 1'b0; dismiss = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
